// File: rtl/dmem_be.sv
// Byte-addressed big-endian data memory with byte/half/word access, valid/ready request port,
// pipelined response with error reporting, and a post-reset clearing sequencer.
module dmem_be #(
   parameter int DEPTH       = 16384,
   parameter int ADDR_W      = 32,
   parameter int CLEAR_WORDS = 256,
   parameter int LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int WORDS = DEPTH / 4;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CLR_W = IDX_W + 1;
   localparam logic [CLR_W-1:0] CLR_LAST = (CLEAR_WORDS == 0) ? '0 : CLR_W'(CLEAR_WORDS - 1);

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;

   // Each word holds four byte lanes; bits [31:24] are the lowest byte address (big-endian).
   logic [31:0]      r_mem [WORDS];
   logic [0:0]       r_state;
   logic [CLR_W-1:0] r_clr_ptr;

   logic             w_run;
   logic             w_accept;
   logic [1:0]       w_off;
   logic [IDX_W-1:0] w_idx;
   logic [1:0]       w_span;
   logic [3:0]       w_be;
   logic [31:0]      w_wal;
   logic [ADDR_W:0]  w_last;
   logic             w_err;
   logic [31:0]      w_rword;
   logic [31:0]      w_sh;
   logic [31:0]      w_load;
   logic [31:0]      w_rdata;

   assign w_run     = (r_state == S_RUN);
   assign req_ready = w_run;
   assign init_done = w_run;
   assign w_accept  = req_valid & w_run;
   assign w_off     = req_addr[1:0];
   assign w_idx     = req_addr[IDX_W+1:2];

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_be   = 4'b0000;
      w_wal  = req_wdata;
      w_span = 2'd0;
      case (req_size)
         2'd0: begin
            w_be  = 4'b1000 >> w_off;
            w_wal = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            w_be   = w_off[1] ? 4'b0011 : 4'b1100;
            w_wal  = {2{req_wdata[15:0]}};
            w_span = 2'd1;
         end
         2'd2: begin
            w_be   = 4'b1111;
            w_span = 2'd3;
         end
         default: ;
      endcase
   end

   // Range check in ADDR_W+1 bits so an access near the top of the address space cannot wrap.
   assign w_last = {1'b0, req_addr} + (ADDR_W+1)'(w_span);
   assign w_err  = (req_size == 2'd3)
                 | ((req_size == 2'd1) & w_off[0])
                 | ((req_size == 2'd2) & (w_off != 2'd0))
                 | (w_last >= (ADDR_W+1)'(DEPTH));

   assign w_rword = r_mem[w_idx];
   assign w_sh    = w_rword << {w_off, 3'b000};

   always_comb begin
      w_load = 32'd0;
      case (req_size)
         2'd0:    w_load = req_unsigned ? {24'd0, w_sh[31:24]} : {{24{w_sh[31]}}, w_sh[31:24]};
         2'd1:    w_load = req_unsigned ? {16'd0, w_sh[31:16]} : {{16{w_sh[31]}}, w_sh[31:16]};
         2'd2:    w_load = w_rword;
         default: w_load = 32'd0;
      endcase
   end

   assign w_rdata = (req_we | w_err) ? 32'd0 : w_load;

   // NOTE: the array has no reset branch so it maps onto RAM; the clear sequencer zeroes it instead.
   always_ff @(posedge clk) begin
      if (!w_run) begin
         if (CLEAR_WORDS != 0) r_mem[r_clr_ptr[IDX_W-1:0]] <= 32'd0;
      end else if (w_accept && req_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wal[8*b +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_CLEAR;
         r_clr_ptr <= '0;
      end else if (r_state == S_CLEAR) begin
         if ((CLEAR_WORDS == 0) || (r_clr_ptr == CLR_LAST)) r_state <= S_RUN;
         else                                               r_clr_ptr <= r_clr_ptr + 1'b1;
      end
   end

   logic        r_s1_valid;
   logic [31:0] r_s1_rdata;
   logic        r_s1_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_rdata <= 32'd0;
         r_s1_err   <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_rdata <= w_rdata;
            r_s1_err   <= w_err;
         end
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic        r_s2_valid;
         logic [31:0] r_s2_rdata;
         logic        r_s2_err;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s2_valid <= 1'b0;
               r_s2_rdata <= 32'd0;
               r_s2_err   <= 1'b0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_rdata <= r_s1_rdata;
                  r_s2_err   <= r_s1_err;
               end
            end
         end

         assign rsp_valid = r_s2_valid;
         assign rsp_rdata = r_s2_rdata;
         assign rsp_err   = r_s2_err;
      end else begin : g_lat1
         assign rsp_valid = r_s1_valid;
         assign rsp_rdata = r_s1_rdata;
         assign rsp_err   = r_s1_err;
      end
   endgenerate

endmodule
